// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// UART transmitter with a small input FIFO. Words from a producer are queued
// in the FIFO and sent LSB first as frames of
//   start(0) + DATA_BITS data + optional parity + STOP_BITS stop(1).
// When the FIFO still holds a word at the end of a frame, the next frame's
// start bit follows the last stop bit directly, so there is no idle gap.
// The bit rate comes from an external one-cycle baud strobe (tx_baud). The
// FSM advances only on that strobe, and tx is a flop, so every bit lasts
// exactly one baud interval.
//
// Handshake (input side): a word is transferred on every rising clock edge
// where in_valid && in_ready are both high. in_ready is !full and is
// combinational from the registered occupancy count, so it never depends on
// in_valid. in_data is don't-care while in_valid is low. A producer may hold
// in_valid high for as long as it likes. The word is taken on the first edge
// where in_ready is also high.
//
// Parameters:
//   DATA_BITS   data bits per frame, 5..9
//   PARITY_MODE 0 = none, 1 = even, 2 = odd
//   STOP_BITS   1 or 2
//   FIFO_DEPTH  FIFO entries, a power of 2, at least 2
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high; aborts any frame and flushes FIFO
//   tx_baud    one-cycle strobe per bit period (may be held high)
//   in_valid   producer has a word on in_data
//   in_data    word to transmit, LSB first
//   in_ready   FIFO can accept a word (= !full)
//   fifo_count occupied FIFO entries
//   busy       FSM is not in IDLE
//   tx_done    one-cycle pulse when a frame's last stop bit completes
//   tx         serial line, idle high
//
// The current FSM state is held in 'state' (type state_t) so a checker can
// bind to it directly.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                tx_baud,
    input  logic                                in_valid,
    input  logic [DATA_BITS-1:0]                in_data,
    output logic                                in_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
    output logic                                busy,
    output logic                                tx_done,
    output logic                                tx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Input FIFO
    // -------------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign in_ready   = !full;
    assign fifo_count = count;
    assign push       = in_valid && !full;
    assign head       = mem[rd_ptr];

    // Storage has no reset; validity is tracked entirely by count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Transmit FSM
    // -------------------------------------------------------------------------
    state_t               state;
    logic [DATA_BITS-1:0] shift;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 par_bit;
    logic                 head_par;
    logic                 frame_end;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    assign head_par  = (PARITY_MODE == 2) ? ~(^head) : (^head);

    assign frame_end = (state == STOP) && (stop_cnt == LAST_STOP);

    // A word is loaded (and popped) on a baud strobe from IDLE, or straight
    // out of the last stop bit for a back-to-back frame. count is registered,
    // so a word pushed on this edge is not visible here until the next one.
    assign pop = tx_baud && !empty && ((state == IDLE) || frame_end);

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (tx_baud) begin
                case (state)
                    IDLE: begin
                        if (!empty) begin
                            shift   <= head;
                            par_bit <= head_par;
                            tx      <= 1'b0;
                            state   <= START;
                        end else begin
                            tx <= 1'b1;
                        end
                    end

                    START: begin
                        tx      <= shift[0];
                        bit_cnt <= '0;
                        state   <= DATA;
                    end

                    DATA: begin
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY_MODE != 0) begin
                                tx    <= par_bit;
                                state <= PARITY;
                            end else begin
                                tx       <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            // shift[1] is the bit that becomes shift[0].
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end

                    PARITY: begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end

                    STOP: begin
                        if (stop_cnt == LAST_STOP) begin
                            tx_done <= 1'b1;
                            if (!empty) begin
                                shift   <= head;
                                par_bit <= head_par;
                                tx      <= 1'b0;
                                state   <= START;
                            end else begin
                                tx    <= 1'b1;
                                state <= IDLE;
                            end
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end

                    default: begin
                        tx    <= 1'b1;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Four instances share clock, reset, tx_baud and in_data, and each has its
// own in_valid bit:
//   dut0: 8 data, no parity, 1 stop
//   dut1: 8 data, even parity, 1 stop
//   dut2: 8 data, odd parity, 1 stop
//   dut3: 7 data, even parity, 2 stops (takes in_data[6:0])
// Inputs are driven and outputs are sampled on the falling edge.
// Expected line streams are written as literal bit strings, leftmost bit
// first on the wire. A long back-to-back run is built from a word queue.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    logic        clock = 1'b0;
    logic        reset;
    logic        tx_baud;
    logic [3:0]  in_valid;
    logic [7:0]  in_data;
    logic [3:0]  in_ready;
    logic [3:0]  busy;
    logic [3:0]  tx_done;
    logic [3:0]  tx;
    logic [11:0] cnt_all;

    always #5 clock = ~clock;

    uart_tx_fifo #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .clock(clock), .reset(reset), .tx_baud(tx_baud), .in_valid(in_valid[0]),
        .in_data(in_data), .in_ready(in_ready[0]), .fifo_count(cnt_all[2:0]),
        .busy(busy[0]), .tx_done(tx_done[0]), .tx(tx[0]));

    uart_tx_fifo #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
        .clock(clock), .reset(reset), .tx_baud(tx_baud), .in_valid(in_valid[1]),
        .in_data(in_data), .in_ready(in_ready[1]), .fifo_count(cnt_all[5:3]),
        .busy(busy[1]), .tx_done(tx_done[1]), .tx(tx[1]));

    uart_tx_fifo #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
        .clock(clock), .reset(reset), .tx_baud(tx_baud), .in_valid(in_valid[2]),
        .in_data(in_data), .in_ready(in_ready[2]), .fifo_count(cnt_all[8:6]),
        .busy(busy[2]), .tx_done(tx_done[2]), .tx(tx[2]));

    uart_tx_fifo #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut3 (
        .clock(clock), .reset(reset), .tx_baud(tx_baud), .in_valid(in_valid[3]),
        .in_data(in_data[6:0]), .in_ready(in_ready[3]), .fifo_count(cnt_all[11:9]),
        .busy(busy[3]), .tx_done(tx_done[3]), .tx(tx[3]));

    int           n_cmp = 0;
    int           n_err = 0;
    int           baud_mode;   // 0 = off, 1 = every 16 clocks, 2 = every clock
    int           div;
    logic [7:0]   feed_q[$];
    logic [3:0]   feed_mask;
    logic [7:0]   exp_q[$];
    logic [127:0] exp_bits [4];
    logic [128:0] done_mark [4];
    int           exp_len [4];

    function automatic logic [2:0] fcount(input int k);
        return cnt_all[3*k +: 3];
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp_v);
        end
    endtask

    // One clock: note any accepted push, move to the next falling edge, then
    // advance the feed queue and set tx_baud for the coming rising edge.
    task automatic cycle();
        logic acc;
        acc = (in_valid != 4'b0) && ((in_ready | ~feed_mask) == 4'hF);
        @(negedge clock);
        if (acc) begin
            void'(feed_q.pop_front());
            if (feed_q.size() > 0) in_data = feed_q[0];
            else in_valid = 4'b0;
        end
        case (baud_mode)
            1: begin
                div = (div + 1) % 16;
                tx_baud = (div == 15);
            end
            2: tx_baud = 1'b1;
            default: tx_baud = 1'b0;
        endcase
    endtask

    task automatic start_feed(input logic [3:0] mask);
        feed_mask = mask;
        in_data   = feed_q[0];
        in_valid  = mask;
    endtask

    task automatic feed_all(input logic [3:0] mask);
        start_feed(mask);
        for (int i = 0; i < 32 && feed_q.size() > 0; i++) cycle();
        chk("feed_drain", 0, feed_q.size(), 0);
    endtask

    task automatic clear_exp();
        for (int k = 0; k < 4; k++) begin
            exp_bits[k]  = '0;
            done_mark[k] = '0;
            exp_len[k]   = 0;
        end
    endtask

    // v holds one frame; its bit n-1 goes on the wire first.
    task automatic add_frame(input int k, input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) exp_bits[k][exp_len[k] + i] = v[n-1-i];
        exp_len[k] = exp_len[k] + n;
        done_mark[k][exp_len[k]] = 1'b1;
    endtask

    task automatic wait_start(input int k);
        for (int i = 0; i < 64; i++) begin
            if (tx[k] === 1'b0) break;
            cycle();
        end
        chk("start_seen", k, tx[k], 0);
    endtask

    // t = 0 is the first sample of the start bit. Checks tx, busy and tx_done
    // of every instance on every clock until all expected streams are over.
    task automatic check_stream(input int w);
        int maxl;
        int idx;
        logic e_tx;
        logic e_busy;
        logic e_done;
        maxl = 0;
        for (int k = 0; k < 4; k++) if (exp_len[k] > maxl) maxl = exp_len[k];
        for (int t = 0; t <= maxl * w; t++) begin
            idx = t / w;
            for (int k = 0; k < 4; k++) begin
                e_tx   = (idx < exp_len[k]) ? exp_bits[k][idx] : 1'b1;
                e_busy = (idx < exp_len[k]);
                e_done = ((t % w) == 0) && done_mark[k][idx];
                chk($sformatf("tx@%0d", t), k, tx[k], e_tx);
                chk($sformatf("busy@%0d", t), k, busy[k], e_busy);
                chk($sformatf("tx_done@%0d", t), k, tx_done[k], e_done);
            end
            cycle();
        end
    endtask

    task automatic check_idle_all(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_tx"}, k, tx[k], 1);
            chk({tag, "_tx_done"}, k, tx_done[k], 0);
            chk({tag, "_busy"}, k, busy[k], 0);
            chk({tag, "_count"}, k, fcount(k), 0);
            chk({tag, "_in_ready"}, k, in_ready[k], 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        logic [7:0]  w;

        // Reset with the baud strobe running.
        reset     = 1'b1;
        tx_baud   = 1'b0;
        in_valid  = 4'b0;
        in_data   = 8'h00;
        feed_mask = 4'b0;
        baud_mode = 1;
        div       = 0;
        repeat (20) cycle();
        check_idle_all("reset");
        reset = 1'b0;
        cycle();

        // 0xA5 into every instance, 16 clocks per bit.
        baud_mode = 0;
        feed_q = {8'hA5};
        feed_all(4'hF);
        for (int k = 0; k < 4; k++) chk("queued_one", k, fcount(k), 1);
        baud_mode = 1;
        div = 0;
        wait_start(0);
        clear_exp();
        add_frame(0, 16'b0101001011, 10);
        add_frame(1, 16'b01010010101, 11);
        add_frame(2, 16'b01010010111, 11);
        add_frame(3, 16'b01010010111, 11);
        check_stream(16);
        check_idle_all("after_a5");

        // 0x07: even parity 1 on dut1, odd parity 0 on dut2.
        baud_mode = 0;
        feed_q = {8'h07};
        feed_all(4'b0110);
        baud_mode = 1;
        div = 0;
        wait_start(1);
        clear_exp();
        add_frame(1, 16'b01110000011, 11);
        add_frame(2, 16'b01110000001, 11);
        check_stream(16);

        // 0x55: 7 data bits with 2 stop bits on dut3, plain frame on dut0.
        baud_mode = 0;
        feed_q = {8'h55};
        feed_all(4'b1001);
        baud_mode = 1;
        div = 0;
        wait_start(0);
        clear_exp();
        add_frame(0, 16'b0101010101, 10);
        add_frame(3, 16'b01010101011, 11);
        check_stream(16);

        // Six words with in_valid held high: fill to full, then back to back.
        baud_mode = 0;
        feed_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        exp_q  = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        start_feed(4'b0001);
        repeat (6) cycle();
        chk("full_count", 0, fcount(0), 4);
        chk("full_in_ready", 0, in_ready[0], 0);
        chk("full_waiting", 0, in_data, 8'h05);
        baud_mode = 1;
        div = 0;
        wait_start(0);
        chk("first_pop_count", 0, fcount(0), 3);
        chk("first_pop_in_ready", 0, in_ready[0], 1);
        clear_exp();
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            v = '0;
            v[9] = 1'b0;
            for (int i = 0; i < 8; i++) v[8-i] = w[i];
            v[0] = 1'b1;
            add_frame(0, v, 10);
        end
        check_stream(16);
        chk("burst_feed_left", 0, feed_q.size(), 0);
        chk("burst_count", 0, fcount(0), 0);

        // Reset during data bit 3 of a frame with two words still queued.
        baud_mode = 0;
        feed_q = {8'h11, 8'h22, 8'h33};
        feed_all(4'b0001);
        baud_mode = 1;
        div = 0;
        wait_start(0);
        chk("queued_two", 0, fcount(0), 2);
        repeat (70) cycle();
        chk("mid_frame_busy", 0, busy[0], 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_idle_all("abort");
        for (int i = 0; i < 48; i++) begin
            cycle();
            chk("post_abort_tx", 0, tx[0], 1);
            chk("post_abort_busy", 0, busy[0], 0);
            chk("post_abort_tx_done", 0, tx_done[0], 0);
        end

        // tx_baud held high: one bit per clock.
        baud_mode = 0;
        feed_q = {8'hA5};
        feed_all(4'hF);
        baud_mode = 2;
        wait_start(0);
        clear_exp();
        add_frame(0, 16'b0101001011, 10);
        add_frame(1, 16'b01010010101, 11);
        add_frame(2, 16'b01010010111, 11);
        add_frame(3, 16'b01010010111, 11);
        check_stream(1);
        check_idle_all("after_fast");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, the next generation of the team's fixed-format UART TX. It adds configurable data width, optional even/odd parity, 1 or 2 stop bits, and an input FIFO with a valid/ready handshake. Back-to-back frames are sent with no idle gap. It sits between a byte producer and the TX pin, and is paced by the shared baud-tick generator.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits; 1 or 2.
FIFO_DEPTH, 4, input FIFO entries; power of 2, at least 2.

Ports:
clock  input  1  sole clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
tx_baud  input  1  one-cycle strobe, once per bit period.
in_valid  input  1  producer has a word on in_data.
in_data  input  DATA_BITS  word to transmit, sent LSB first.
in_ready  output  1  FIFO can accept a word; equal to !full.
fifo_count  output  $clog2(FIFO_DEPTH+1)  number of occupied FIFO entries.
busy  output  1  high whenever the FSM is not in IDLE.
tx_done  output  1  one-cycle pulse when a frame's last stop bit completes.
tx  output  1  serial line, idle high.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: tx=1, tx_done=0, busy=0, FIFO empty, fifo_count=0, in_ready=1. All registers are outputs of flops.
- Reset mid-frame: the frame is aborted, the FIFO is flushed, and tx=1 on the cycle after reset is sampled. There is no partial stop bit.
- FIFO push: occurs when in_valid && in_ready. in_ready is combinational !full, so overflow is impossible. in_data is ignored while in_valid=0.
- FIFO pop: occurs only when the FSM loads a frame, and only if fifo_count>0 is registered. A word pushed in cycle N cannot be popped before cycle N+1.
- Simultaneous push and pop: both take effect and fifo_count is unchanged. When full, no push is possible, so the pop frees one entry.
- Parity: computed when the word is loaded. Even parity = XOR of the data bits. Odd parity = its inverse.
- FSM states: IDLE, START, DATA, PARITY, STOP. The FSM moves only on tx_baud; tx is registered, so every bit lasts exactly one baud interval.
- IDLE: tx=1. On tx_baud with FIFO non-empty: pop into the shift register, latch parity, set tx<=0, go to START.
- START: on tx_baud: tx<=shift[0], bit_cnt<=0, go to DATA.
- DATA: on tx_baud:
  - If bit_cnt==DATA_BITS-1: go to PARITY with tx<=parity when PARITY_MODE!=0. Otherwise go to STOP with tx<=1 and stop_cnt<=0.
  - Else: shift right, tx<=next bit, bit_cnt++.
- PARITY: on tx_baud: tx<=1, stop_cnt<=0, go to STOP.
- STOP: on tx_baud:
  - If stop_cnt==STOP_BITS-1: pulse tx_done for exactly one cycle. Then, if the FIFO is non-empty, pop and go to START with tx<=0 (back-to-back frame). Otherwise go to IDLE with tx=1.
  - Else: stop_cnt++.
- Frame length: 1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS baud intervals.
- tx_baud held high continuously: one bit per clock; the design must remain correct.
- tx_baud low: all state holds; the FIFO still accepts pushes.

Test Plan:
1. Defaults, push 0xA5, tick every 16 clocks -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 clocks wide; one tx_done pulse; busy=1 from the frame start until the return to IDLE.
2. PARITY_MODE=1, push 0x07 -> parity bit 1. PARITY_MODE=2, push 0xA5 -> parity bit 1. PARITY_MODE=1, push 0xA5 -> parity bit 0.
3. STOP_BITS=2, DATA_BITS=7, push 0x55 -> 11-interval frame ending in two high bits; tx_done fires only after the second stop bit.
4. FIFO_DEPTH=4, in_valid held high with 0x01..0x06 while the line is busy -> in_ready drops when fifo_count=4; frames are sent back-to-back with no idle interval, in order 0x01..0x06; six tx_done pulses.
5. Assert reset during the DATA bit 3 of a frame with 2 words queued -> tx=1, fifo_count=0, busy=0 on the next cycle; no tx_done pulse; the line stays idle.
6. Push a word with tx_baud held high -> each bit lasts exactly one clock; the frame matches scenario 1 compressed to 10 clocks.
